cic_comp_fir: RTL and testbench



---
 rtl/cic_comp_pkg.sv | 34 +++
 rtl/cic_comp_mac.sv | 73 +++++++
 rtl/cic_comp_fir.sv | 134 +++++++++++++
 tb/tb_cic_comp_fir.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/cic_comp_pkg.sv
// Shared constants, coefficient table and FSM encoding for the CIC compensation FIR.
// Optional decimate-by-2 output mode is selected with CIC_COMP_DECIM2_EN.
package cic_comp_pkg;

  localparam int W     = 16;
  localparam int WC    = 16;
  localparam int NTAP  = 15;
  localparam int WACC  = 40;
  localparam int NHALF = (NTAP + 1) / 2;
  localparam int KW    = $clog2(NHALF);
  localparam int XW    = $clog2(NTAP);
  localparam int SHIFT = 15;

  localparam logic [KW-1:0] CTR = KW'(NHALF - 1);

  localparam logic signed [WACC-1:0] RND =
    {{(WACC-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  localparam logic signed [WACC-1:0] SAT_HI = {{(WACC-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [WACC-1:0] SAT_LO = {{(WACC-W+1){1'b1}}, {(W-1){1'b0}}};

  // Half of a symmetric Q1.15 response, centre tap last; 2*sum(0..6) + COEF[7] = 32768.
  localparam logic signed [WC-1:0] COEF [NHALF] = '{
    -16'sd121, 16'sd301, -16'sd700, 16'sd1500,
    -16'sd1500, 16'sd4000, -16'sd2500, 16'sd30808
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/cic_comp_mac.sv
// Pre-adder, single multiplier, accumulator and round/saturate stage of the
// compensation FIR.
module cic_comp_mac
  import cic_comp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 center,
  input  logic                 rnd,
  input  logic signed [W-1:0]  xa,
  input  logic signed [W-1:0]  xb,
  input  logic signed [WC-1:0] coef,
  output logic signed [W-1:0]  o_data
);

  logic signed [W:0]      pre_s;
  logic signed [W+WC:0]   prod_s;
  logic signed [WACC-1:0] acc_r;
  logic signed [WACC-1:0] sum_s;
  logic signed [WACC-1:0] sh_s;
  logic signed [W-1:0]    sat_s;
  logic signed [W-1:0]    o_data_r;

  // Fold the mirrored tap pair; the centre tap has no partner.
  always_comb begin
    pre_s = {xa[W-1], xa};
    if (center) begin
      pre_s = {xa[W-1], xa};
    end else begin
      pre_s = {xa[W-1], xa} + {xb[W-1], xb};
    end
  end

  assign prod_s = (W+WC+1)'(pre_s) * (W+WC+1)'(coef);

  // Round half-up, drop the Q1.15 fraction and clip to the output range.
  always_comb begin
    sum_s = acc_r + RND;
    sh_s  = sum_s >>> SHIFT;
    if (sh_s > SAT_HI) begin
      sat_s = SAT_HI[W-1:0];
    end else if (sh_s < SAT_LO) begin
      sat_s = SAT_LO[W-1:0];
    end else begin
      sat_s = sh_s[W-1:0];
    end
  end

  // Accumulator: cleared at sequence start, one product per MAC cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r <= {WACC{1'b0}};
    end else if (clr) begin
      acc_r <= {WACC{1'b0}};
    end else if (en) begin
      acc_r <= acc_r + WACC'(prod_s);
    end
  end

  // Output register holds the last result between strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_data_r <= {W{1'b0}};
    end else if (rnd) begin
      o_data_r <= sat_s;
    end
  end

  assign o_data = o_data_r;

endmodule

// File: rtl/cic_comp_fir.sv
// Symmetric compensation FIR behind the CIC decimator: FSM, delay line and flags.
// Define CIC_COMP_DECIM2_EN to emit one output per two accepted samples.
module cic_comp_fir
  import cic_comp_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] i_data,
  input  logic                val_in,
  output logic signed [W-1:0] o_data,
  output logic                val_out,
  output logic                busy,
  output logic                overrun
);

  state_t              state_r;
  state_t              state_nx_s;
  logic [KW-1:0]       k_r;
  logic [KW-1:0]       k_nx_s;
  logic signed [W-1:0] x_r [NTAP];
  logic [XW-1:0]       ka_s;
  logic [XW-1:0]       kb_s;
  logic                busy_r;
  logic                val_out_r;
  logic                ovr_r;
  logic                accept_s;
  logic                start_s;
  logic                clr_s;
  logic                en_s;
  logic                rnd_s;
  logic                center_s;

  assign accept_s = val_in & ~busy_r;

`ifdef CIC_COMP_DECIM2_EN
  logic phase_r;

  // Phase toggle: only every second accepted sample launches a MAC sequence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_r <= 1'b0;
    end else if (accept_s) begin
      phase_r <= ~phase_r;
    end
  end

  assign start_s = accept_s & phase_r;
`else
  assign start_s = accept_s;
`endif

  assign center_s = (k_r == CTR);
  assign ka_s     = XW'(k_r);
  assign kb_s     = XW'(NTAP - 1) - ka_s;

  // Next-state and datapath control.
  always_comb begin
    state_nx_s = state_r;
    k_nx_s     = k_r;
    clr_s      = 1'b0;
    en_s       = 1'b0;
    rnd_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_nx_s = MAC;
          k_nx_s     = {KW{1'b0}};
          clr_s      = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      MAC: begin
        en_s = 1'b1;
        if (center_s) begin
          state_nx_s = ROUND;
        end else begin
          k_nx_s = k_r + KW'(1);
        end
      end
      ROUND: begin
        rnd_s      = 1'b1;
        state_nx_s = OUT;
      end
      OUT:     state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State, tap index and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      k_r       <= {KW{1'b0}};
      busy_r    <= 1'b0;
      val_out_r <= 1'b0;
      ovr_r     <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      k_r       <= k_nx_s;
      busy_r    <= (state_nx_s != IDLE);
      val_out_r <= (state_nx_s == OUT);
      ovr_r     <= ovr_r | (val_in & busy_r);
    end
  end

  // Delay line, x_r[0] newest; samples arriving while busy never reach it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NTAP; i++) x_r[i] <= {W{1'b0}};
    end else if (accept_s) begin
      x_r[0] <= i_data;
      for (int i = 1; i < NTAP; i++) x_r[i] <= x_r[i-1];
    end
  end

  cic_comp_mac u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr_s),
    .en     (en_s),
    .center (center_s),
    .rnd    (rnd_s),
    .xa     (x_r[ka_s]),
    .xb     (x_r[kb_s]),
    .coef   (COEF[k_r]),
    .o_data (o_data)
  );

  assign val_out = val_out_r;
  assign busy    = busy_r;
  assign overrun = ovr_r;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed bench for cic_comp_fir: impulse, DC, saturation, overrun and reset
// mid-sequence; the CIC_COMP_DECIM2_EN build runs a decimated impulse test.
module tb_cic_comp_fir;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic signed [15:0] i_data = 16'sd0;
  logic               val_in = 1'b0;
  logic signed [15:0] o_data;
  logic               val_out;
  logic               busy;
  logic               overrun;

  int n_chk = 0;
  int n_err = 0;

  int imp_exp [15] = '{-60, 151, -350, 750, -750, 2000, -1250, 15404,
                       -1250, 2000, -750, 750, -350, 151, -60};
  int dec_exp [8]  = '{151, 750, 2000, 15404, 2000, 750, 151, 0};

  always #5 clk = ~clk;

  cic_comp_fir dut (
    .clk     (clk),
    .rst     (rst),
    .i_data  (i_data),
    .val_in  (val_in),
    .o_data  (o_data),
    .val_out (val_out),
    .busy    (busy),
    .overrun (overrun)
  );

  task automatic check(input string tag, input logic signed [31:0] got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the sampling edge.
  task automatic pulse(input int data);
    i_data = 16'(data);
    val_in = 1'b1;
    @(negedge clk);
    val_in = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int exp, input int lat0, input bit do_data);
    int lat = lat0;
    bit seen = 1'b0;
    while (!seen && lat < 40) begin
      if (val_out) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    check({tag, " latency"}, seen ? lat : -1, 10);
    if (do_data) check({tag, " data"}, o_data, exp);
    @(negedge clk);
    check({tag, " strobe width"}, val_out, 0);
  endtask

  task automatic send(input int data, input int exp, input bit do_data, input string tag);
    pulse(data);
    wait_out(tag, exp, 1, do_data);
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset o_data", o_data, 0);
    check("reset val_out", val_out, 0);
    check("reset busy", busy, 0);
    check("reset overrun", overrun, 0);
    rst = 1'b1;
    @(negedge clk);

`ifndef CIC_COMP_DECIM2_EN
    for (int s = 0; s < 15; s++)
      send((s == 0) ? 16384 : 0, imp_exp[s], 1'b1, $sformatf("impulse[%0d]", s));

    do_reset();
    for (int s = 0; s < 30; s++)
      send(1000, 1000, (s >= 14), $sformatf("dc[%0d]", s));

    do_reset();
    for (int s = 0; s < 20; s++)
      send((s % 2 == 0) ? 32767 : -32768, (s % 2 == 0) ? -32768 : 32767,
           (s >= 14), $sformatf("sat[%0d]", s));
    check("no overrun in normal flow", overrun, 0);

    // Second sample lands three cycles into the first sequence and is dropped.
    do_reset();
    pulse(16384);
    repeat (2) @(negedge clk);
    pulse(5000);
    check("overrun set", overrun, 1);
    wait_out("overrun first", -60, 4, 1'b1);
    repeat (8) @(negedge clk);
    send(0, 151, 1'b1, "overrun next");
    check("overrun sticky", overrun, 1);

    // Reset four cycles into a sequence.
    pulse(16384);
    repeat (3) @(negedge clk);
    check("pre-reset busy", busy, 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async reset o_data", o_data, 0);
    check("async reset busy", busy, 0);
    check("async reset overrun", overrun, 0);
    @(negedge clk);
    rst = 1'b1;
    begin
      int nv = 0;
      for (int c = 0; c < 15; c++) begin
        @(negedge clk);
        if (val_out) nv++;
      end
      check("no strobe after reset", nv, 0);
    end
    send(16384, -60, 1'b1, "post-reset impulse");
`else
    for (int s = 0; s < 16; s++) begin
      if (s % 2 == 0) begin
        pulse((s == 0) ? 16384 : 0);
        repeat (3) @(negedge clk);
        check($sformatf("decim idle busy[%0d]", s), busy, 0);
        repeat (14) @(negedge clk);
      end else begin
        send(0, dec_exp[s/2], 1'b1, $sformatf("decim impulse[%0d]", s));
      end
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
